// File: rtl/iiitb_fetch_queue_if.sv
// Fetch-queue bundle: instruction-memory read port, redirect from execute,
// and the valid/ready instruction handoff to decode.
interface iiitb_fetch_queue_if #(
  parameter int AW = 5
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          id_ready;
  logic          if_valid;
  logic [31:0]   if_instr;
  logic [31:0]   if_pc;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_rdata, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_rdata, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/iiitb_fetch_queue.sv
// Instruction fetch front-end: PC generation, sync-read imem issue and an in-order
// {instr, pc} queue to decode. Optional starvation counter under IFQ_STALL_COUNT_EN.
module iiitb_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          AW       = 5,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic               clk,
  input  logic               rst_n,
  iiitb_fetch_queue_if.master bus
`ifdef IFQ_STALL_COUNT_EN
  ,
  output logic [15:0]        stall_cycles
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   r_fetch_pc;
  logic          r_inflight;
  logic [31:0]   r_inflight_pc;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_instr_q [DEPTH];
  logic [31:0]   r_pc_q    [DEPTH];

  logic          w_redirect;
  logic          w_if_valid;
  logic          w_pop;
  logic          w_push;
  logic          w_issue;
  logic [CW:0]   w_occ;

  assign w_redirect = bus.redirect_valid;
  assign w_if_valid = (r_count != '0) & ~w_redirect;
  assign w_pop      = w_if_valid & bus.id_ready;
  assign w_push     = r_inflight & ~w_redirect;
  // Occupancy after this cycle's pop; pop implies count >= 1, so no underflow.
  assign w_occ      = (CW+1)'(r_count) + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
  // rst_n gate keeps the request low while reset is asserted.
  assign w_issue    = rst_n & ~w_redirect & (w_occ < (CW+1)'(DEPTH));

  assign bus.imem_req  = w_issue;
  assign bus.imem_addr = r_fetch_pc[AW-1:0];
  assign bus.if_valid  = w_if_valid;
  assign bus.if_instr  = r_instr_q[r_rd_ptr];
  assign bus.if_pc     = r_pc_q[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_redirect) begin
        r_fetch_pc <= bus.redirect_pc;
      end else if (w_issue) begin
        r_fetch_pc    <= r_fetch_pc + 32'd1;
        r_inflight_pc <= r_fetch_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_redirect) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_instr_q[i] <= '0;
        r_pc_q[i]    <= '0;
      end
    end else if (w_push) begin
      r_instr_q[r_wr_ptr] <= bus.imem_rdata;
      r_pc_q[r_wr_ptr]    <= r_inflight_pc;
    end
  end

`ifdef IFQ_STALL_COUNT_EN
  logic [15:0] r_stall;

  // Decode ready but nothing to hand over; saturates, survives redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall <= '0;
    end else if (bus.id_ready & ~w_if_valid & (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign stall_cycles = r_stall;
`endif
endmodule

// File: tb/tb_iiitb_fetch_queue.sv
// Directed bench for iiitb_fetch_queue with a sync-read memory model, MEM[i] = 32'h100 + i.
module tb_iiitb_fetch_queue;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [31:0] mem [32];

  iiitb_fetch_queue_if #(.AW(5)) bus ();

`ifdef IFQ_STALL_COUNT_EN
  logic [15:0] stall_cycles;
`endif

  iiitb_fetch_queue #(.DEPTH(4), .AW(5), .RESET_PC(32'd0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
`ifdef IFQ_STALL_COUNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= mem[bus.imem_addr];
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.id_ready = rdy;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.id_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bus.if_valid, bus.imem_req} !== 2'b00) begin
      $display("FAIL reset_ctrl got valid/req=%b exp=00", {bus.if_valid, bus.imem_req});
      failures++;
    end
    checks++;
    if ({bus.if_instr, bus.if_pc} !== 64'd0) begin
      $display("FAIL reset_head got instr=%h pc=%h exp=0", bus.if_instr, bus.if_pc);
      failures++;
    end
    checks++;
    if (bus.imem_addr !== 5'd0) begin
      $display("FAIL reset_addr got=%h exp=0", bus.imem_addr);
      failures++;
    end
  endtask

  task automatic test_streaming();
    do_reset(1'b1);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if (bus.if_valid !== (c >= 2)) begin
        $display("FAIL stream_valid c=%0d got=%b exp=%b", c, bus.if_valid, (c >= 2));
        failures++;
      end
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 5'(c)) begin
        $display("FAIL stream_req c=%0d got req=%b addr=%h exp req=1 addr=%h", c, bus.imem_req, bus.imem_addr, 5'(c));
        failures++;
      end
      if (c >= 2) begin
        checks++;
        if (bus.if_pc !== 32'(c - 2) || bus.if_instr !== 32'h100 + 32'(c - 2)) begin
          $display("FAIL stream_head c=%0d got pc=%h instr=%h exp pc=%h instr=%h", c, bus.if_pc, bus.if_instr, 32'(c - 2), 32'h100 + 32'(c - 2));
          failures++;
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    int nreq;
    nreq = 0;
    do_reset(1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.imem_req) nreq++;
      if (c >= 2) begin
        checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'd0 || bus.if_instr !== 32'h100) begin
          $display("FAIL bp_hold c=%0d got v=%b pc=%h instr=%h exp v=1 pc=0 instr=100", c, bus.if_valid, bus.if_pc, bus.if_instr);
          failures++;
        end
      end
      next_cycle();
    end
    checks++;
    if (nreq != 4) begin
      $display("FAIL bp_reqs got=%0d exp=4", nreq);
      failures++;
    end
    bus.id_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'(c) || bus.if_instr !== 32'h100 + 32'(c)) begin
        $display("FAIL bp_drain i=%0d got v=%b pc=%h instr=%h exp v=1 pc=%h", c, bus.if_valid, bus.if_pc, bus.if_instr, 32'(c));
        failures++;
      end
      next_cycle();
    end
  endtask

  task automatic test_flush();
    do_reset(1'b0);
    repeat (4) next_cycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h10;
    @(negedge clk);
    checks++;
    if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
      $display("FAIL flush_pulse got v=%b req=%b exp 0 0", bus.if_valid, bus.imem_req);
      failures++;
    end
    next_cycle();
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.id_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 5'h10 || bus.if_valid !== 1'b0) begin
      $display("FAIL flush_restart got req=%b addr=%h v=%b exp req=1 addr=10 v=0", bus.imem_req, bus.imem_addr, bus.if_valid);
      failures++;
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.if_valid !== 1'b0) begin
      $display("FAIL flush_gap got v=%b exp=0", bus.if_valid);
      failures++;
    end
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h10 + 32'(i) || bus.if_instr !== 32'h110 + 32'(i)) begin
        $display("FAIL flush_deliver i=%0d got v=%b pc=%h instr=%h exp pc=%h", i, bus.if_valid, bus.if_pc, bus.if_instr, 32'h10 + 32'(i));
        failures++;
      end
      next_cycle();
    end
  endtask

  task automatic test_redirect_response();
    do_reset(1'b1);
    next_cycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h4;
    @(negedge clk);
    checks++;
    if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
      $display("FAIL rsp_redirect got v=%b req=%b exp 0 0", bus.if_valid, bus.imem_req);
      failures++;
    end
    next_cycle();
    bus.redirect_pc = 32'h8;
    next_cycle();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 5'h8 || bus.if_valid !== 1'b0) begin
      $display("FAIL rsp_lastpc got req=%b addr=%h v=%b exp req=1 addr=08 v=0", bus.imem_req, bus.imem_addr, bus.if_valid);
      failures++;
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.if_valid !== 1'b0) begin
      $display("FAIL rsp_dropped got v=%b exp=0", bus.if_valid);
      failures++;
    end
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h8 + 32'(i) || bus.if_instr !== 32'h108 + 32'(i)) begin
        $display("FAIL rsp_first i=%0d got v=%b pc=%h instr=%h exp pc=%h", i, bus.if_valid, bus.if_pc, bus.if_instr, 32'h8 + 32'(i));
        failures++;
      end
      next_cycle();
    end
  endtask

  task automatic test_wrap();
    do_reset(1'b1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFF;
    next_cycle();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 5'h1F) begin
      $display("FAIL wrap_addr got req=%b addr=%h exp req=1 addr=1f", bus.imem_req, bus.imem_addr);
      failures++;
    end
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'hFFFF_FFFF || bus.if_instr !== 32'h11F) begin
      $display("FAIL wrap_top got v=%b pc=%h instr=%h exp pc=ffffffff instr=11f", bus.if_valid, bus.if_pc, bus.if_instr);
      failures++;
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0 || bus.if_instr !== 32'h100) begin
      $display("FAIL wrap_zero got v=%b pc=%h instr=%h exp pc=0 instr=100", bus.if_valid, bus.if_pc, bus.if_instr);
      failures++;
    end
    next_cycle();
  endtask

  task automatic test_async_reset();
    do_reset(1'b0);
    repeat (6) next_cycle();
    @(negedge clk);
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0) begin
      $display("FAIL areset_pre got v=%b pc=%h exp v=1 pc=0", bus.if_valid, bus.if_pc);
      failures++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.if_valid, bus.imem_req} !== 2'b00 || {bus.if_instr, bus.if_pc} !== 64'd0 || bus.imem_addr !== 5'd0) begin
      $display("FAIL areset_now got v=%b req=%b instr=%h pc=%h addr=%h exp all 0", bus.if_valid, bus.imem_req, bus.if_instr, bus.if_pc, bus.imem_addr);
      failures++;
    end
    next_cycle();
    rst_n = 1'b1;
    bus.id_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 5'd0) begin
      $display("FAIL areset_restart got req=%b addr=%h exp req=1 addr=0", bus.imem_req, bus.imem_addr);
      failures++;
    end
    next_cycle();
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'(i) || bus.if_instr !== 32'h100 + 32'(i)) begin
        $display("FAIL areset_stream i=%0d got v=%b pc=%h instr=%h exp pc=%h", i, bus.if_valid, bus.if_pc, bus.if_instr, 32'(i));
        failures++;
      end
      next_cycle();
    end
  endtask

`ifdef IFQ_STALL_COUNT_EN
  task automatic test_stall_count();
    do_reset(1'b1);
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.if_valid !== 1'b1 || stall_cycles !== 16'd2) begin
      $display("FAIL stall_first got v=%b stall=%0d exp v=1 stall=2", bus.if_valid, stall_cycles);
      failures++;
    end
    bus.redirect_valid = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (stall_cycles !== 16'hFFFF) begin
      $display("FAIL stall_sat got=%h exp=ffff", stall_cycles);
      failures++;
    end
    bus.redirect_valid = 1'b0;
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h100 + 32'(i);
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.id_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_redirect_response();
    test_wrap();
    test_async_reset();
`ifdef IFQ_STALL_COUNT_EN
    test_stall_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/iiitb_fetch_queue.md
# iiitb_fetch_queue

Instruction fetch front-end for the 5-stage RV32 pipeline. It generates a word-indexed PC, issues reads to a synchronous-read instruction memory and buffers the returned words with their PCs in a small in-order queue. It presents one instruction per cycle to the decode stage over a valid/ready handshake. A single-cycle redirect from execute flushes all queued and in-flight fetches and restarts from the branch target.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `AW`, 5: instruction-memory word-address width.
- `RESET_PC`, 32'd0: first PC fetched after reset.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `imem_req`  out  1  read request this cycle.
- `imem_addr`  out  AW  word address, equal to `fetch_pc[AW-1:0]`.
- `imem_rdata`  in  32  read data, valid exactly one cycle after `imem_req`.
- `redirect_valid`  in  1  flush and restart, single-cycle pulse or held.
- `redirect_pc`  in  32  restart PC, sampled when `redirect_valid`=1.
- `id_ready`  in  1  decode accepts the head entry this cycle.
- `if_valid`  out  1  head entry valid.
- `if_instr`  out  32  head instruction.
- `if_pc`  out  32  PC of head instruction.
- `stall_cycles`  out  16  starvation counter; only with `IFQ_STALL_COUNT_EN`.

## Operation
- **State:** `fetch_pc`, `inflight` flag plus `inflight_pc`, and a circular queue of {instr, pc} with rd/wr pointers and `count` (0..DEPTH).
- **Pop:** `pop = if_valid & id_ready & ~redirect_valid`.
- **Issue:** `imem_req = ~redirect_valid & (count + inflight - pop < DEPTH)`.
  - `imem_req` depends combinationally on `id_ready`.
  - On issue, `inflight_pc <= fetch_pc` and `fetch_pc <= fetch_pc + 1`.
  - `fetch_pc` wraps modulo 2^32. `imem_addr` truncates, so memory wraps every 2^AW words.
- **Push:** in the cycle after an issue, the entry {`imem_rdata`, `inflight_pc`} is written at wr_ptr, unless a redirect is active that cycle.
  - Overflow is impossible by construction of the issue condition.
  - Push and pop in the same cycle leave `count` unchanged.
- **Head:** `if_valid = (count != 0) & ~redirect_valid`. `if_instr` and `if_pc` are read from rd_ptr (show-ahead).
- **Redirect cycle:**
  - `count <= 0` and both pointers are reset.
  - Any response arriving this cycle is dropped.
  - No issue and no pop occur.
  - `fetch_pc <= redirect_pc`.
  - When held for several cycles, the last `redirect_pc` wins.
- **Ordering:** instructions are delivered strictly in fetch order. No PC is duplicated or skipped except across a redirect.

## Timing
- **Reset values while `rst_n`=0:**
  - `if_valid`=0, `if_instr`=0, `if_pc`=0.
  - `imem_req`=0, `imem_addr`=`RESET_PC[AW-1:0]`.
  - `stall_cycles`=0; queue storage cleared to 0; `inflight`=0.
- **Reset release:** first `imem_req` in the first cycle after `rst_n` rises.
- **Fetch latency:** request in cycle k, data pushed at the end of k+1, `if_valid` high in cycle k+2.
- **Throughput:** one instruction per cycle while `id_ready`=1.
- **Redirect latency:** redirect in cycle r, first request from `redirect_pc` in r+1, `if_valid` in r+3.
- **Backpressure:** with `id_ready`=0, requests stop once `count + inflight` = DEPTH. Head outputs hold stable until popped.
- **Reset mid-operation:** asynchronously clears all state. An in-flight response is ignored.

## Configuration
- **`IFQ_STALL_COUNT_EN` defined:**
  - `stall_cycles` increments on every cycle with `id_ready`=1, `if_valid`=0 and `rst_n`=1.
  - It saturates at 16'hFFFF and is not cleared by redirect.
- **Undefined:** the port and its counter are absent; all other behaviour is identical.

## Test plan
- **Streaming:** reset, `id_ready`=1, `MEM[i]`=32'h100+i. First `if_valid` 2 cycles after the first `imem_req`, then pc 0,1,2,... with instr 32'h100,32'h101,... every cycle and no bubbles.
- **Backpressure:** `id_ready`=0 for 10 cycles from start. Exactly 4 requests issue, head holds pc 0 and instr 32'h100. Release → pcs 0..3 then 4.. in order, none lost or repeated.
- **Flush:** `redirect_valid` pulse with `redirect_pc`=32'h10 while 3 entries are queued and 1 is in flight. `if_valid`=0 during the pulse. Next delivered pc is 32'h10 with instr `MEM[16]`; no stale pc appears.
- **Response on redirect:** redirect asserted in the cycle a response returns → the response is dropped, `count` stays 0, and the first entry after the redirect carries `redirect_pc`.
- **Async reset mid-stream:** drop `rst_n` mid-clock with a full queue → outputs reach reset values immediately. After release, fetch restarts at `RESET_PC`.
- **Stall counter (`IFQ_STALL_COUNT_EN`):** `id_ready`=1 across reset release → `stall_cycles`=2 when the first `if_valid` rises. A forced 70000-cycle starvation → `stall_cycles` reads 16'hFFFF.
